// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the pipeline control and the PC generator.
// The pipeline side is master; pc_gen is slave.
interface pc_gen_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               branch_flag_i;
  logic [ADDR_W-1:0]  branch_target_address_i;
  logic [ADDR_W-1:0]  pc;
  logic               ce;
  logic               redirect_pending;
  logic               misalign_o;

  modport master (
    output stall, flush, new_pc,
    output branch_flag_i, branch_target_address_i,
    input  pc, ce, redirect_pending, misalign_o
  );

  modport slave (
    input  stall, flush, new_pc,
    input  branch_flag_i, branch_target_address_i,
    output pc, ce, redirect_pending, misalign_o
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with flush/branch redirect and stall-buffered branch.
// Optional target alignment check enabled by PC_ALIGN_CHECK_EN.
module pc_gen #(
  parameter int                ADDR_W     = 32,
  parameter int                ALIGN_BITS = 2,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                STALL_W    = 6
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.slave  bus
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(1) << ALIGN_BITS;

  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              redir;
  logic [ADDR_W-1:0] redir_addr;
  logic              stall0;
  logic              unused_stall;

  assign stall0       = bus.stall[0];
  assign unused_stall = ^bus.stall;

  // flush beats everything, including a stall; a fresh branch beats a buffered one
  always_comb begin
    ce_d        = ce_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    redir       = 1'b0;
    redir_addr  = '0;
    if (!ce_q) begin
      ce_d = 1'b1;
    end else if (bus.flush) begin
      redir      = 1'b1;
      redir_addr = bus.new_pc;
      pend_d     = 1'b0;
    end else if (!stall0 && bus.branch_flag_i) begin
      redir      = 1'b1;
      redir_addr = bus.branch_target_address_i;
      pend_d     = 1'b0;
    end else if (!stall0 && pend_q) begin
      redir      = 1'b1;
      redir_addr = pend_addr_q;
      pend_d     = 1'b0;
    end else if (!stall0) begin
      pc_d = pc_q + INC;
    end else if (bus.branch_flag_i) begin
      pend_addr_d = bus.branch_target_address_i;
      pend_d      = 1'b1;
    end
`ifdef PC_ALIGN_CHECK_EN
    if (redir) pc_d = redir_addr & ~(INC - 1'b1);
`else
    if (redir) pc_d = redir_addr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q        <= 1'b0;
      pc_q        <= RESET_VEC;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      ce_q        <= ce_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = redir && |(redir_addr & (INC - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign bus.misalign_o = misalign_q;
`else
  assign bus.misalign_o = 1'b0;
`endif

  assign bus.pc               = pc_q;
  assign bus.ce               = ce_q;
  assign bus.redirect_pending = pend_q;

endmodule
